// File: rtl/scaler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scaler_pkg
//  Description : Shared definitions for the scaler output line-buffer reader.
//                Contains the read FSM state encoding, buffer status
//                constants, the HOLD length and a line-length clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package scaler_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_HOLD  = 3'd5
    } rd_state_t;

    // Buffer status as seen on rempty
    localparam logic REMPTY    = 1'b0;
    localparam logic RNONEMPTY = 1'b1;

    // The buffer's status flag is registered from its space counter and
    // lags the bank release by this many cycles.
    localparam int HOLD_CYCLES = 2;

    localparam int LEN_W = 12;

    function automatic logic [LEN_W-1:0] clamp_len(
        input logic [LEN_W-1:0] width,
        input logic [LEN_W-1:0] max_len
    );
        return (width > max_len) ? max_len : width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scaler_vout_skid.sv
`default_nettype none
// ============================================================================
//  Module      : scaler_vout_skid
//  Description : Small synchronous FIFO that absorbs the BRAM read latency.
//                The producer is credit-controlled, so no full flag is
//                needed. The head entry is presented combinationally.
//  Ports       : clk, rst (async, active-high)
//                push/wdata  - write one entry
//                pop         - remove head entry (ignored when empty)
//                count       - number of stored entries
//                valid       - FIFO not empty
//                head        - oldest entry
//  Revision    : 1.0 - initial release
// ============================================================================
module scaler_vout_skid
    import scaler_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop & valid;
    assign head   = mem[rd_ptr];

    // Storage is reset so the head (and therefore the pixel output) reads
    // as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/scaler_vout_rd.sv
`default_nettype none
// ============================================================================
//  Module      : scaler_vout_rd
//  Description : Read-side controller for the scaler output ping-pong line
//                buffer. Waits for a filled bank, reads one line from it,
//                absorbs the BRAM latency in a skid FIFO and streams the
//                pixels out on a valid/ready interface. Pulses rdone to free
//                the bank once the last pixel has been accepted.
//  Ports       : core_clk, core_rst (async, active-high)
//                line_width      - pixels per line, sampled on READ entry
//                rempty          - 1 = at least one bank filled
//                enb/addrb/doutb - BRAM read port (two banks, one-hot enb)
//                rdone           - one-cycle bank release pulse
//                m_valid/m_ready/m_data/m_last - pixel stream
//                line_cnt        - completed line count (optional)
//  Options     : SCALER_VOUT_RD_LINE_CNT_EN adds the line_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module scaler_vout_rd
    import scaler_pkg::*;
#(
    parameter int BRAM_DEEP          = 1920,
    parameter int BRAM_ADDR_BITWIDTH = 11,
    parameter int BRAM_DATA_BITWIDTH = 8,
    parameter int BRAM_DELAY         = 2
) (
    input  logic                            core_clk,
    input  logic                            core_rst,
    input  logic [LEN_W-1:0]                line_width,
    input  logic                            rempty,
    output logic [1:0]                      enb,
    output logic [BRAM_ADDR_BITWIDTH-1:0]   addrb,
    input  logic [2*BRAM_DATA_BITWIDTH-1:0] doutb,
    output logic                            rdone,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [BRAM_DATA_BITWIDTH-1:0]   m_data,
    output logic                            m_last
`ifdef SCALER_VOUT_RD_LINE_CNT_EN
    ,
    output logic [15:0]                     line_cnt
`endif
);

    localparam int FIFO_DEPTH = BRAM_DELAY + 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_W     = BRAM_DATA_BITWIDTH + 1;
    localparam int HOLD_W     = 2;

    localparam logic [CNT_W:0]     CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0]   MAX_LEN    = LEN_W'(BRAM_DEEP);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

    rd_state_t                     state;
    rd_state_t                     state_nxt;
    logic                          rd_bank;
    logic [BRAM_ADDR_BITWIDTH-1:0] rd_addr;
    logic [LEN_W-1:0]              len;
    logic [HOLD_W-1:0]             hold_cnt;
    logic [CNT_W-1:0]              inflight;

    // Per-read tags travelling alongside the BRAM latency
    logic [BRAM_DELAY-1:0]         tag_vld;
    logic [BRAM_DELAY-1:0]         tag_bank;
    logic [BRAM_DELAY-1:0]         tag_last;

    logic [CNT_W-1:0]              fifo_count;
    logic [FIFO_W-1:0]             fifo_head;
    logic [FIFO_W-1:0]             fifo_wdata;
    logic                          fifo_push;
    logic                          fifo_valid;

    logic [CNT_W:0]                credit_used;
    logic                          credit_ok;
    logic                          issue;
    logic                          last_issue;
    logic                          line_start;
    logic                          hs_last;
    logic [BRAM_DATA_BITWIDTH-1:0] ret_data;

    // ------------------------------------------------------------------
    // Read issue: a read may only be issued while the words already in
    // flight plus those sitting in the FIFO leave room for its return.
    // ------------------------------------------------------------------
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit_ok   = (credit_used < CREDIT_MAX);
    assign issue       = (state == S_READ) && credit_ok;
    assign last_issue  = issue && (LEN_W'(rd_addr) == (len - 1'b1));
    assign line_start  = (state == S_WAIT) && (rempty == RNONEMPTY) &&
                         (line_width != '0);

    assign enb   = issue ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    assign addrb = rd_addr;
    assign rdone = (state == S_DONE);

    assign m_valid = fifo_valid;
    assign m_data  = fifo_head[BRAM_DATA_BITWIDTH-1:0];
    assign m_last  = fifo_head[BRAM_DATA_BITWIDTH];
    assign hs_last = m_valid & m_ready & m_last;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_WAIT;
            S_WAIT:  if (line_start) state_nxt = S_READ;
            S_READ:  if (last_issue) state_nxt = S_DRAIN;
            S_DRAIN: if (hs_last)    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_HOLD;
            S_HOLD:  if (hold_cnt == HOLD_LAST) state_nxt = S_WAIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Line bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            rd_bank  <= 1'b0;
            rd_addr  <= '0;
            len      <= '0;
            hold_cnt <= '0;
        end else begin
            if (line_start) begin
                len <= clamp_len(line_width, MAX_LEN);
            end

            if (state == S_DONE) begin
                rd_bank <= ~rd_bank;
                rd_addr <= '0;
            end else if (issue) begin
                rd_addr <= rd_addr + 1'b1;
            end

            hold_cnt <= (state == S_HOLD) ? hold_cnt + 1'b1 : '0;
        end
    end

    // ------------------------------------------------------------------
    // Latency pipeline: tags emerge from the last stage in the same cycle
    // the BRAM presents the matching word on doutb.
    // ------------------------------------------------------------------
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            tag_vld  <= '0;
            tag_bank <= '0;
            tag_last <= '0;
            inflight <= '0;
        end else begin
            tag_vld[0]  <= issue;
            tag_bank[0] <= rd_bank;
            tag_last[0] <= last_issue;
            for (int i = 1; i < BRAM_DELAY; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_bank[i] <= tag_bank[i-1];
                tag_last[i] <= tag_last[i-1];
            end
            inflight <= inflight + CNT_W'(issue) - CNT_W'(tag_vld[BRAM_DELAY-1]);
        end
    end

    assign ret_data   = tag_bank[BRAM_DELAY-1] ?
                        doutb[2*BRAM_DATA_BITWIDTH-1:BRAM_DATA_BITWIDTH] :
                        doutb[BRAM_DATA_BITWIDTH-1:0];
    assign fifo_push  = tag_vld[BRAM_DELAY-1];
    assign fifo_wdata = {tag_last[BRAM_DELAY-1], ret_data};

    scaler_vout_skid #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_skid (
        .clk   (core_clk),
        .rst   (core_rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (m_ready),
        .count (fifo_count),
        .valid (fifo_valid),
        .head  (fifo_head)
    );

`ifdef SCALER_VOUT_RD_LINE_CNT_EN
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            line_cnt <= '0;
        end else if (state == S_DONE) begin
            line_cnt <= line_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_scaler_vout_rd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scaler_vout_rd
//  Description : Directed self-checking bench for scaler_vout_rd with a
//                two-bank BRAM model of read latency 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scaler_vout_rd;

    logic        clk = 1'b0;
    logic        core_rst;
    logic [11:0] line_width;
    logic        rempty;
    logic [1:0]  enb;
    logic [10:0] addrb;
    logic [15:0] doutb = '0;
    logic [15:0] bram_p1 = '0;
    logic        rdone;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scaler_vout_rd dut (
        .core_clk   (clk),
        .core_rst   (core_rst),
        .line_width (line_width),
        .rempty     (rempty),
        .enb        (enb),
        .addrb      (addrb),
        .doutb      (doutb),
        .rdone      (rdone),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    // Pixel content of bank b at address a
    function automatic logic [7:0] pv(input logic b, input int a);
        int v;
        v = b ? (a * 5 + 7) : (a * 3 + 1);
        return v[7:0];
    endfunction

    // Two-cycle BRAM: address registered with enb, output register behind it
    always @(posedge clk) begin
        if (enb[0]) bram_p1[7:0]  <= pv(1'b0, int'(addrb));
        if (enb[1]) bram_p1[15:8] <= pv(1'b1, int'(addrb));
        doutb <= bram_p1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one line with rempty held high. Returns two cycles after rdone,
    // mimicking the buffer's lagging status flag.
    task automatic run_line(input string tag, input int lw, input int exp_len,
                            input logic bank, input bit toggle,
                            input int exp_first_enb, input int exp_first_valid);
        int k, reads, pix, rdones, first_enb, last_enb, first_val, rd_k, last_k, over, budget;
        k = 0; reads = 0; pix = 0; rdones = 0; first_enb = -1; last_enb = -1;
        first_val = -1; rd_k = -1; last_k = -1; over = 0;
        budget = exp_len * 3 + 40;
        line_width = 12'(lw);
        rempty     = 1'b1;
        while (k < budget && !(rdones > 0 && k >= rd_k + 2)) begin
            @(negedge clk);
            k++;
            m_ready = toggle ? k[0] : 1'b1;
            if (enb != 2'b00) begin
                if (first_enb < 0) first_enb = k;
                last_enb = k;
                chk({tag, " enb"}, 32'(enb), bank ? 32'd2 : 32'd1);
                chk({tag, " addrb"}, 32'(addrb), reads);
                reads++;
            end
            if (int'(dut.inflight) + int'(dut.fifo_count) > 4) over++;
            if (m_valid && m_ready) begin
                if (first_val < 0) first_val = k;
                chk({tag, " m_data"}, 32'(m_data), 32'(pv(bank, pix)));
                chk({tag, " m_last"}, 32'(m_last), 32'(pix == exp_len - 1));
                if (m_last) last_k = k;
                pix++;
            end
            if (rdone) begin
                rdones++;
                rd_k = k;
            end
        end
        chk({tag, " reads"}, reads, exp_len);
        chk({tag, " pixels"}, pix, exp_len);
        chk({tag, " rdone_count"}, rdones, 1);
        chk({tag, " rdone_after_last"}, rd_k, last_k + 1);
        chk({tag, " credit_bound"}, over, 0);
        if (exp_first_enb >= 0) chk({tag, " first_enb"}, first_enb, exp_first_enb);
        if (exp_first_valid >= 0) chk({tag, " first_valid"}, first_val, exp_first_valid);
        if (!toggle) chk({tag, " enb_burst"}, last_enb - first_enb + 1, exp_len);
    endtask

    initial begin
        int bad, pix, k, rd;
        core_rst   = 1'b1;
        line_width = '0;
        rempty     = 1'b0;
        m_ready    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst enb", 32'(enb), 0);
        chk("rst addrb", 32'(addrb), 0);
        chk("rst rdone", 32'(rdone), 0);
        chk("rst m_valid", 32'(m_valid), 0);
        chk("rst m_last", 32'(m_last), 0);
        chk("rst m_data", 32'(m_data), 0);
        core_rst = 1'b0;

        // Empty buffer, then zero-width line: nothing may be read or released
        line_width = 12'd8;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (enb != 2'b00 || rdone || m_valid) bad++;
        end
        chk("idle empty", bad, 0);
        line_width = 12'd0;
        rempty     = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (enb != 2'b00 || rdone || m_valid) bad++;
        end
        chk("idle zero_width", bad, 0);

        // Basic line, then a back-to-back line on the other bank after HOLD
        run_line("basic", 8, 8, 1'b0, 1'b0, 1, 4);
        run_line("hold", 8, 8, 1'b1, 1'b0, 2, 5);

        // Backpressure with m_ready toggling
        run_line("bp", 16, 16, 1'b0, 1'b1, 2, -1);

        // Width clamp to bank depth
        run_line("clamp", 2000, 1920, 1'b1, 1'b0, 2, 5);

        // Short line so the next line reads bank 1
        run_line("short", 4, 4, 1'b0, 1'b0, 2, 5);

        // Reset in the middle of a bank-1 line
        line_width = 12'd10;
        rempty     = 1'b1;
        m_ready    = 1'b1;
        pix = 0; k = 0; rd = 0;
        while (pix < 5 && k < 100) begin
            @(negedge clk);
            k++;
            if (m_valid && m_ready) begin
                chk("midrst m_data", 32'(m_data), 32'(pv(1'b1, pix)));
                pix++;
            end
            if (rdone) rd++;
        end
        chk("midrst pixels", pix, 5);
        @(posedge clk);
        #1 core_rst = 1'b1;
        #1;
        chk("midrst enb", 32'(enb), 0);
        chk("midrst addrb", 32'(addrb), 0);
        chk("midrst m_valid", 32'(m_valid), 0);
        chk("midrst m_data", 32'(m_data), 0);
        chk("midrst m_last", 32'(m_last), 0);
        chk("midrst rdone", 32'(rdone), 0);
        rempty = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rdone || m_valid || enb != 2'b00) rd++;
        end
        core_rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rdone || m_valid || enb != 2'b00) rd++;
        end
        chk("midrst no_activity", rd, 0);

        // After reset the next line starts on bank 0 at address 0
        run_line("post_rst", 10, 10, 1'b0, 1'b0, 1, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
